// File: rtl/qam_demapper_pkg.sv
// Shared definitions for the QAM demapper: mode encodings, per-mode lookups
// and the Gray mapping applied to each sliced axis index.
package qam_demapper_pkg;

  localparam logic [1:0] MODE_QPSK  = 2'b00;
  localparam logic [1:0] MODE_16QAM = 2'b01;
  localparam logic [1:0] MODE_64QAM = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic {ST_IDLE, ST_ACC} state_t;

  // The reserved encoding is demapped as QPSK.
  function automatic logic [1:0] eff_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_QPSK : m;
  endfunction

  function automatic logic [3:0] levels(input logic [1:0] m);
    case (m)
      MODE_16QAM: return 4'd4;
      MODE_64QAM: return 4'd8;
      default:    return 4'd2;
    endcase
  endfunction

  function automatic logic [1:0] bits_per_axis(input logic [1:0] m);
    case (m)
      MODE_16QAM: return 2'd2;
      MODE_64QAM: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

  function automatic logic [2:0] bits_per_sym(input logic [1:0] m);
    case (m)
      MODE_16QAM: return 3'd4;
      MODE_64QAM: return 3'd6;
      default:    return 3'd2;
    endcase
  endfunction

  function automatic logic [4:0] syms_per_word(input logic [1:0] m);
    case (m)
      MODE_16QAM: return 5'd8;
      MODE_64QAM: return 5'd5;
      default:    return 5'd16;
    endcase
  endfunction

  function automatic logic [2:0] gray_decode(input logic [2:0] idx);
    return idx ^ (idx >> 1);
  endfunction

endpackage

// File: rtl/qam_demapper_if.sv
// Symbol-in / word-out AXI4-Stream pair of the QAM demapper.
// The demapper takes the slave modport, the symbol source/word sink the master.
interface qam_demapper_if;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [4:0]  m_axis_tuser;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/qam_axis_slicer.sv
// One-axis hard slicer: nearest level index, clamped to the constellation,
// then Gray mapped. Purely combinational.
module qam_axis_slicer
  import qam_demapper_pkg::*;
#(
  parameter int STEP_SHIFT = 10
) (
  input  logic [15:0] x,
  input  logic [1:0]  mode,
  output logic [2:0]  g,
  output logic        clip
);

  logic signed [17:0] x_ext;
  logic signed [17:0] t;
  logic signed [17:0] t_max;
  logic [2:0]         idx;

  always_comb begin
    x_ext = {{2{x[15]}}, x};
    t     = (x_ext >>> (STEP_SHIFT + 1)) + signed'({14'd0, levels(mode)} >> 1);
    t_max = signed'({14'd0, levels(mode)}) - 18'sd1;
    idx   = '0;
    clip  = 1'b0;
    if (t[17]) begin
      clip = 1'b1;
    end else if (t > t_max) begin
      idx  = t_max[2:0];
      clip = 1'b1;
    end else begin
      idx = t[2:0];
    end
    g = gray_decode(idx);
  end

endmodule

// File: rtl/qam_demapper.sv
// Hard-decision QAM demapper: slices I/Q symbols and packs Gray bits into
// 32-bit words. Optional clip counter enabled by QAM_DEMAP_SAT_CNT_EN.
//   state   | meaning
//   ST_IDLE | between packets; next accepted symbol latches mode
//   ST_ACC  | inside a packet; mode held, symbols accumulating
module qam_demapper
  import qam_demapper_pkg::*;
#(
  parameter int STEP_SHIFT = 10,
  parameter int SAT_CNT_W  = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [1:0]           mode,
  qam_demapper_if.slave        axis,
  output logic                 mode_err,
  output logic [SAT_CNT_W-1:0] sat_count
);

  state_t      state, state_next;
  logic [1:0]  mode_lat;
  logic [1:0]  mode_cur;
  logic [31:0] acc, acc_next;
  logic [4:0]  count, count_next;
  logic [4:0]  shamt;
  logic [5:0]  sym_bits;
  logic        accept;
  logic        close;
  logic [2:0]  g_i, g_q;
  logic        clip_i, clip_q;

  assign axis.s_axis_tready = !axis.m_axis_tvalid || axis.m_axis_tready;
  assign accept   = axis.s_axis_tvalid && axis.s_axis_tready;
  // First symbol of a packet is sliced with the live mode it latches.
  assign mode_cur = (state == ST_IDLE) ? eff_mode(mode) : mode_lat;

  qam_axis_slicer #(.STEP_SHIFT(STEP_SHIFT)) u_slice_i (
    .x    (axis.s_axis_tdata[15:0]),
    .mode (mode_cur),
    .g    (g_i),
    .clip (clip_i)
  );

  qam_axis_slicer #(.STEP_SHIFT(STEP_SHIFT)) u_slice_q (
    .x    (axis.s_axis_tdata[31:16]),
    .mode (mode_cur),
    .g    (g_q),
    .clip (clip_q)
  );

  always_comb begin
    sym_bits   = ({3'b0, g_i} << bits_per_axis(mode_cur)) | {3'b0, g_q};
    shamt      = count * {2'b0, bits_per_sym(mode_cur)};
    acc_next   = acc | ({26'd0, sym_bits} << shamt);
    count_next = count + 5'd1;
    close      = accept && ((count_next == syms_per_word(mode_cur)) || axis.s_axis_tlast);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = axis.s_axis_tlast ? ST_IDLE : ST_ACC;
      ST_ACC:  if (accept && axis.s_axis_tlast) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      mode_lat           <= MODE_QPSK;
      mode_err           <= 1'b0;
      acc                <= '0;
      count              <= '0;
      axis.m_axis_tdata  <= '0;
      axis.m_axis_tuser  <= '0;
      axis.m_axis_tlast  <= 1'b0;
      axis.m_axis_tvalid <= 1'b0;
    end else begin
      if (accept && state == ST_IDLE) begin
        mode_lat <= eff_mode(mode);
        if (mode == MODE_RSVD) mode_err <= 1'b1;
      end
      if (close) begin
        axis.m_axis_tdata  <= acc_next;
        axis.m_axis_tuser  <= count_next;
        axis.m_axis_tlast  <= axis.s_axis_tlast;
        axis.m_axis_tvalid <= 1'b1;
        acc                <= '0;
        count              <= '0;
      end else begin
        if (accept) begin
          acc   <= acc_next;
          count <= count_next;
        end
        if (axis.m_axis_tready) axis.m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef QAM_DEMAP_SAT_CNT_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sat_count <= '0;
    end else if (accept && (clip_i || clip_q) && !(&sat_count)) begin
      sat_count <= sat_count + SAT_CNT_W'(1);
    end
  end
`else
  logic unused_clip;
  assign unused_clip = clip_i | clip_q;
  assign sat_count   = '0;
`endif

endmodule

// File: tb/tb_qam_demapper.sv
// Self-checking bench for qam_demapper: directed packets plus randomized
// symbols against an arithmetic reference model of the demapping rules.
module tb_qam_demapper;

  localparam int STEP_SHIFT = 10;
  localparam int SAT_CNT_W  = 16;
`ifdef QAM_DEMAP_SAT_CNT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic                 ACLK = 1'b0;
  logic                 ARESET = 1'b1;
  logic [1:0]           mode = 2'b00;
  logic                 mode_err;
  logic [SAT_CNT_W-1:0] sat_count;

  qam_demapper_if axis();

  qam_demapper #(.STEP_SHIFT(STEP_SHIFT), .SAT_CNT_W(SAT_CNT_W)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .mode      (mode),
    .axis      (axis),
    .mode_err  (mode_err),
    .sat_count (sat_count)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  user;
    logic        last;
  } word_t;

  word_t  exp_q[$];
  bit     m_idle = 1'b1;
  int     m_mode = 0;
  int     m_cnt = 0;
  longint m_word = 0;
  bit     exp_mode_err = 1'b0;
  int     exp_sat = 0;

  function automatic int floor_step(input int v);
    int s;
    s = 1 << (STEP_SHIFT + 1);
    if (v >= 0) return v / s;
    return -((-v + s - 1) / s);
  endfunction

  function automatic int slice(input int v, input int lv, output bit clipped);
    int t, idx;
    t = floor_step(v) + lv / 2;
    clipped = (t < 0) || (t > lv - 1);
    idx = (t < 0) ? 0 : ((t > lv - 1) ? lv - 1 : t);
    return idx ^ (idx >> 1);
  endfunction

  task automatic model_accept(input logic [15:0] i, input logic [15:0] q,
                              input bit last, input logic [1:0] md);
    int lv, b, spw, gi, gq, vi, vq;
    bit ci, cq;
    word_t w;
    if (m_idle) begin
      m_mode = (md == 2'b11) ? 0 : int'(md);
      if (md == 2'b11) exp_mode_err = 1'b1;
      m_idle = 1'b0;
    end
    lv  = 2 << m_mode;
    b   = m_mode + 1;
    spw = (m_mode == 0) ? 16 : ((m_mode == 1) ? 8 : 5);
    vi  = $signed(i);
    vq  = $signed(q);
    gi  = slice(vi, lv, ci);
    gq  = slice(vq, lv, cq);
    if ((ci || cq) && exp_sat < 65535) exp_sat++;
    m_word += longint'(gi * (1 << b) + gq) << (m_cnt * 2 * b);
    m_cnt++;
    if (m_cnt == spw || last) begin
      w.data = m_word[31:0];
      w.user = 5'(m_cnt);
      w.last = last;
      exp_q.push_back(w);
      m_word = 0;
      m_cnt  = 0;
      m_idle = last;
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_cnt = 0;
    m_word = 0;
    exp_mode_err = 1'b0;
    exp_sat = 0;
    exp_q.delete();
  endtask

  // ---------------- output monitor ----------------
  int          words_seen = 0;
  logic [31:0] last_data;
  logic [4:0]  last_user;
  logic        last_last;
  bit          hold_pend = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_user;
  logic        hold_last;

  always @(negedge ACLK) begin
    word_t w;
    if (ARESET) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", axis.m_axis_tvalid, 1);
        check("hold_data", axis.m_axis_tdata, hold_data);
        check("hold_user", axis.m_axis_tuser, hold_user);
        check("hold_last", axis.m_axis_tlast, hold_last);
      end
      hold_pend = axis.m_axis_tvalid && !axis.m_axis_tready;
      hold_data = axis.m_axis_tdata;
      hold_user = axis.m_axis_tuser;
      hold_last = axis.m_axis_tlast;
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        words_seen++;
        last_data = axis.m_axis_tdata;
        last_user = axis.m_axis_tuser;
        last_last = axis.m_axis_tlast;
        check("word_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("model_data", axis.m_axis_tdata, w.data);
          check("model_user", axis.m_axis_tuser, w.user);
          check("model_last", axis.m_axis_tlast, w.last);
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic send_sym(input logic [15:0] i, input logic [15:0] q, input bit last,
                          input logic [1:0] md, input bit rnd_rdy);
    bit acc_s;
    int n;
    acc_s = 1'b0;
    n = 0;
    axis.s_axis_tdata  = {q, i};
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tlast  = last;
    mode = md;
    while (!acc_s) begin
      if (rnd_rdy) axis.m_axis_tready = ($urandom_range(0, 3) != 0);
      @(negedge ACLK);
      acc_s = axis.s_axis_tready;
      @(posedge ACLK);
      #1;
      n++;
      if (!acc_s && n >= 200) begin
        check("send_timeout", axis.s_axis_tready, 1);
        break;
      end
    end
    if (acc_s) model_accept(i, q, last, md);
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_words(input int target, input string tag);
    int n;
    n = 0;
    while (words_seen < target && n < 200) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    check(tag, (words_seen >= target) ? 1 : 0, 1);
  endtask

  task automatic check_word(input string tag, input logic [31:0] d, input logic [4:0] u,
                            input logic l);
    check({tag, "_data"}, last_data, d);
    check({tag, "_user"}, last_user, u);
    check({tag, "_last"}, last_last, l);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base, n;
    logic [15:0] ri, rq;
    axis.s_axis_tdata  = '0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast  = 1'b0;
    axis.m_axis_tready = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_tvalid", axis.m_axis_tvalid, 0);
    check("rst_tdata", axis.m_axis_tdata, 0);
    check("rst_tuser", axis.m_axis_tuser, 0);
    check("rst_tlast", axis.m_axis_tlast, 0);
    check("rst_mode_err", mode_err, 0);
    check("rst_sat", sat_count, 0);
    ARESET = 1'b0;

    // QPSK full word, no tlast
    base = words_seen;
    for (int k = 0; k < 16; k++) send_sym(16'h0400, 16'hFC00, 1'b0, 2'b00, 1'b0);
    wait_words(base + 1, "qpsk16_wait");
    check_word("qpsk16", 32'hAAAAAAAA, 5'd16, 1'b0);
    send_sym(16'h0400, 16'h0400, 1'b1, 2'b00, 1'b0);
    wait_words(base + 2, "qpsk1_wait");
    check_word("qpsk1", 32'h00000003, 5'd1, 1'b1);

    // 16QAM packet of 8
    base = words_seen;
    for (int k = 0; k < 8; k++) send_sym(16'h0C00, 16'hF400, k == 7, 2'b01, 1'b0);
    wait_words(base + 1, "qam16_wait");
    check_word("qam16", 32'h88888888, 5'd8, 1'b1);

    // 64QAM, both axes clipped
    base = words_seen;
    for (int k = 0; k < 5; k++) send_sym(16'h7FFF, 16'h8000, k == 4, 2'b10, 1'b0);
    wait_words(base + 1, "qam64_wait");
    check_word("qam64", 32'h20820820, 5'd5, 1'b1);
    check("qam64_sat", sat_count, SAT_EN ? 5 : 0);

    // short QPSK packet, then a 16QAM packet proves mode relatched from IDLE
    base = words_seen;
    for (int k = 0; k < 3; k++) send_sym(16'h0400, 16'h0400, k == 2, 2'b00, 1'b0);
    wait_words(base + 1, "short_wait");
    check_word("short", 32'h0000003F, 5'd3, 1'b1);
    send_sym(16'h0C00, 16'h0400, 1'b1, 2'b01, 1'b0);
    wait_words(base + 2, "relatch_wait");
    check_word("relatch", 32'h0000000B, 5'd1, 1'b1);

    // backpressure with a word pending
    base = words_seen;
    axis.m_axis_tready = 1'b0;
    for (int k = 0; k < 16; k++) send_sym(16'h0400, 16'hFC00, 1'b0, 2'b00, 1'b0);
    axis.s_axis_tdata  = {16'h0400, 16'h0400};
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tlast  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      check("bp_s_ready", axis.s_axis_tready, 0);
      check("bp_valid", axis.m_axis_tvalid, 1);
      check("bp_data", axis.m_axis_tdata, 32'hAAAAAAAA);
      @(posedge ACLK);
      #1;
    end
    axis.m_axis_tready = 1'b1;
    send_sym(16'h0400, 16'h0400, 1'b1, 2'b00, 1'b0);
    wait_words(base + 2, "bp_wait");
    check_word("bp_tail", 32'h00000003, 5'd1, 1'b1);
    check("bp_count", words_seen - base, 2);

    // reserved mode
    base = words_seen;
    for (int k = 0; k < 2; k++) send_sym(16'h0400, 16'hFC00, k == 1, 2'b11, 1'b0);
    wait_words(base + 1, "rsvd_wait");
    check_word("rsvd", 32'h0000000A, 5'd2, 1'b1);
    check("rsvd_mode_err", mode_err, 1);

    // reset mid-packet
    base = words_seen;
    for (int k = 0; k < 4; k++) send_sym(16'h0C00, 16'hF400, 1'b0, 2'b01, 1'b0);
    ARESET = 1'b1;
    model_reset();
    @(posedge ACLK);
    #1;
    check("mid_rst_tvalid", axis.m_axis_tvalid, 0);
    check("mid_rst_tdata", axis.m_axis_tdata, 0);
    check("mid_rst_tuser", axis.m_axis_tuser, 0);
    check("mid_rst_tlast", axis.m_axis_tlast, 0);
    check("mid_rst_mode_err", mode_err, 0);
    check("mid_rst_sat", sat_count, 0);
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    repeat (4) @(posedge ACLK);
    #1;
    check("mid_rst_no_word", words_seen - base, 0);
    for (int k = 0; k < 3; k++) send_sym(16'h0400, 16'h0400, k == 2, 2'b00, 1'b0);
    wait_words(base + 1, "post_rst_wait");
    check_word("post_rst", 32'h0000003F, 5'd3, 1'b1);
    check("post_rst_mode_err", mode_err, 0);

    // randomized symbols, modes, packet ends and downstream ready
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        ri = 16'($urandom);
        rq = 16'($urandom);
      end else begin
        ri = 16'($urandom_range(0, 20000) - 10000);
        rq = 16'($urandom_range(0, 20000) - 10000);
      end
      send_sym(ri, rq, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), 1'b1);
    end
    send_sym(16'h0400, 16'h0400, 1'b1, 2'b00, 1'b1);
    axis.m_axis_tready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge ACLK);
      #1;
      n++;
    end
    check("rand_drain", exp_q.size(), 0);
    check("rand_mode_err", mode_err, exp_mode_err);
    check("rand_sat", sat_count, SAT_EN ? exp_sat : 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
